// File: rtl/dm_arbiter.sv
// Two-master arbiter for the single-ported data memory: burst-limited ownership,
// fair alternation on contention, registered per-master read return.
module dm_arbiter #(
  parameter int bit_size  = 32,
  parameter int mem_size  = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [mem_size-1:0] m0_addr,
  input  logic [bit_size-1:0] m0_wdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [mem_size-1:0] m1_addr,
  input  logic [bit_size-1:0] m1_wdata,
  output logic                m0_gnt,
  output logic                m1_gnt,
  output logic                m0_rvalid,
  output logic                m1_rvalid,
  output logic [bit_size-1:0] m0_rdata,
  output logic [bit_size-1:0] m1_rdata,
  output logic [mem_size-1:0] DM_Address,
  output logic                DM_enable,
  output logic [bit_size-1:0] DM_Write_Data,
  input  logic [bit_size-1:0] DM_Read_Data
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             last_gnt_q, last_gnt_d;   // 0 = M0, 1 = M1
  logic             m0_rvalid_q, m1_rvalid_q;
  logic [bit_size-1:0] m0_rdata_q, m1_rdata_q;
  logic             burst_ok;

  assign burst_ok = (burst_cnt_q < BURST_MAX);

  // Grant priority: continuing owner, then hand-over, then sole requester, then tie-break.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst) begin
      if (owner_q == OWN_M0 && m0_req && (burst_ok || !m1_req))      m0_gnt = 1'b1;
      else if (owner_q == OWN_M1 && m1_req && (burst_ok || !m0_req)) m1_gnt = 1'b1;
      else if (owner_q == OWN_M0 && m1_req)                          m1_gnt = 1'b1;
      else if (owner_q == OWN_M1 && m0_req)                          m0_gnt = 1'b1;
      else if (m0_req && !m1_req)                                    m0_gnt = 1'b1;
      else if (m1_req && !m0_req)                                    m1_gnt = 1'b1;
      else if (m0_req && m1_req) begin
        if (last_gnt_q) m0_gnt = 1'b1;
        else            m1_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    DM_Address    = '0;
    DM_Write_Data = '0;
    DM_enable     = 1'b0;
    if (m0_gnt) begin
      DM_Address    = m0_addr;
      DM_Write_Data = m0_wdata;
      DM_enable     = m0_we;
    end else if (m1_gnt) begin
      DM_Address    = m1_addr;
      DM_Write_Data = m1_wdata;
      DM_enable     = m1_we;
    end
  end

  always_comb begin
    owner_d     = OWN_NONE;
    burst_cnt_d = '0;
    last_gnt_d  = last_gnt_q;
    if (m0_gnt || m1_gnt) begin
      owner_d    = m0_gnt ? OWN_M0 : OWN_M1;
      last_gnt_d = m1_gnt;
      if (owner_d == owner_q)
        burst_cnt_d = (burst_cnt_q == BURST_MAX) ? BURST_MAX : burst_cnt_q + 1'b1;
      else
        burst_cnt_d = CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // Read data is reset too: masters may sample rdata before their first read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_NONE;
      burst_cnt_q <= '0;
      last_gnt_q  <= 1'b1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      last_gnt_q  <= last_gnt_d;
      m0_rvalid_q <= m0_gnt && !m0_we;
      m1_rvalid_q <= m1_gnt && !m1_we;
      if (m0_gnt && !m0_we) m0_rdata_q <= DM_Read_Data;
      if (m1_gnt && !m1_we) m1_rdata_q <= DM_Read_Data;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single-ported data memory (DM) between the CPU load/store port (M0) and a second bus master (M1, DMA/loader). It sits between the masters and the DM block and drives the existing DM port signals. Per cycle it grants at most one master. It bounds back-to-back ownership with a burst limit, alternates fairly on contention, and returns registered read data with a one-cycle valid pulse.

## Interface
- bit_size, 32: data width.
- mem_size, 16: address width.
- MAX_BURST, 4: max consecutive grants to one master while the other is requesting (≥1).

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req / m1_req  in  1  access request, level; held until granted.
- m0_we / m1_we  in  1  1 = write, 0 = read; valid with req.
- m0_addr / m1_addr  in  mem_size  word address.
- m0_wdata / m1_wdata  in  bit_size  write data.
- m0_gnt / m1_gnt  out  1  combinational; access performed this cycle.
- m0_rvalid / m1_rvalid  out  1  registered; one-cycle pulse, read data ready.
- m0_rdata / m1_rdata  out  bit_size  registered read data; holds until next read by that master.
- DM_Address  out  mem_size  to DM.
- DM_enable  out  1  DM write enable.
- DM_Write_Data  out  bit_size  to DM.
- DM_Read_Data  in  bit_size  from DM; combinational read of DM_Address.

## Operation
- Registers: owner ∈ {NONE, M0, M1}; burst_cnt (counts 1..MAX_BURST, saturating); last_gnt ∈ {M0, M1}; rvalid/rdata per master.
- Grant decision is combinational from the registers and the requests:
  - If owner = k, mk_req = 1, and either burst_cnt < MAX_BURST or the other master is idle, grant k.
  - Otherwise, if the other master requests, grant the other master.
  - Otherwise, if exactly one master requests, grant it.
  - If both request and neither rule above applies, grant the master that is not last_gnt.
  - If nothing is granted, both gnt = 0.
- Datapath muxing: the granted master's addr and wdata drive DM_Address and DM_Write_Data. DM_enable = gnt & we of the granted master.
- With no grant: DM_Address = 0, DM_Write_Data = 0, DM_enable = 0.
- Register update on each clk edge:
  - owner ← granted master, or NONE if no grant.
  - burst_cnt ← min(burst_cnt+1, MAX_BURST) if the granted master equals the previous owner; else 1. It becomes 0 when there is no grant.
  - last_gnt ← granted master; unchanged when there is no grant.
- Reads: when a read is granted, DM_Read_Data is captured into mk_rdata and mk_rvalid = 1 for exactly the next cycle. Writes never raise rvalid.
- Fairness: under continuous contention the pattern is MAX_BURST grants to one master, then MAX_BURST to the other.
- Starvation-free: worst-case wait is MAX_BURST cycles.

## Timing
- Grant latency: 0 cycles. gnt is in the same cycle as req when the master wins.
- DM write commits at the edge ending the grant cycle.
- Read latency: rvalid/rdata appear 1 cycle after the grant cycle.
- Reset (rst = 0, asynchronous, any time including mid-burst):
  - owner = NONE, burst_cnt = 0, last_gnt = M1 (so M0 wins the first tie).
  - m0_rvalid = m1_rvalid = 0, m0_rdata = m1_rdata = 0.
  - gnt and DM_enable are forced 0 while rst = 0.
  - An in-flight read's rvalid is dropped.
- Deassertion of rst: arbitration resumes on the first clk edge after rst returns high.
- Boundaries:
  - MAX_BURST = 1 gives strict alternation under contention.
  - The owner dropping req mid-burst hands ownership over immediately, with no idle cycle.
  - A sole requester keeps the grant indefinitely; the counter saturates and does not wrap.
  - Same-cycle write by M1 followed by a read of the same address by M0 in the next cycle returns the new data.

## Test plan
- Reset: drive rst = 0 mid-burst with m0_req = 1 → gnt = 0, DM_enable = 0, rvalid = 0, rdata = 0 immediately. After release with both requesting, M0 is granted first.
- Single master: M0 writes 0xDEADBEEF to addr 5, then reads addr 5 → m0_gnt = 1 both cycles. m0_rvalid pulses 1 cycle after the read with m0_rdata = 0xDEADBEEF. m1_rvalid stays 0.
- Contention, MAX_BURST = 4: both masters hold req for 16 cycles → grants M0×4, M1×4, M0×4, M1×4.
- Early release: M0 owns with burst_cnt = 2 and drops req while M1 requests → M1 granted that same cycle and burst_cnt = 1 next cycle.
- Write/read ordering: M1 writes 0x12345678 to addr 9 while M0 waits; M0 is then granted a read of addr 9 → m0_rdata = 0x12345678.
- Saturation: M1 requests alone for 10 cycles, then M0 requests → M0 granted on the first cycle after its request arrives. burst_cnt never exceeds 4.
